// File: rtl/wb_sram_model_pkg.sv
// wb_sram_model_pkg: shared Wishbone cycle-type constants, burst-type and slave-state enums
package wb_sram_model_pkg;
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;
  typedef enum logic [1:0] {BTE_LINEAR, BTE_WRAP4, BTE_WRAP8, BTE_WRAP16} bte_e;
  typedef enum logic [1:0] {IDLE, WAIT, RESP, GAP} state_e;
endpackage

// File: rtl/wb_if.sv
// wb_if: Wishbone B4 bus bundle with master and slave views
interface wb_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   ADR;
  logic [DATA_WIDTH-1:0]   DAT_W;
  logic [DATA_WIDTH-1:0]   DAT_R;
  logic [DATA_WIDTH/8-1:0] SEL;
  logic                    CYC;
  logic                    STB;
  logic                    WE;
  logic [2:0]              CTI;
  logic [1:0]              BTE;
  logic                    ACK;
  logic                    ERR;
  modport master (output ADR, DAT_W, SEL, CYC, STB, WE, CTI, BTE, input DAT_R, ACK, ERR);
  modport slave  (input ADR, DAT_W, SEL, CYC, STB, WE, CTI, BTE, output DAT_R, ACK, ERR);
endinterface

// File: rtl/wb_burst_addr_next.sv
// wb_burst_addr_next: next word index of a Wishbone incrementing burst
//   idx_i  : current word index
//   bte_i  : burst type (linear, wrap-4, wrap-8, wrap-16)
//   next_o : word index of the following beat
module wb_burst_addr_next import wb_sram_model_pkg::*; #(
  parameter int IDX_W = 10
) (
  input  logic [IDX_W-1:0] idx_i,
  input  bte_e             bte_i,
  output logic [IDX_W-1:0] next_o
);
  logic [IDX_W-1:0] m;
  // only the bits under the mask advance; the rest pin the wrap block
  assign m = bte_i == BTE_WRAP4  ? IDX_W'(3)  :
             bte_i == BTE_WRAP8  ? IDX_W'(7)  :
             bte_i == BTE_WRAP16 ? IDX_W'(15) : '1;
  assign next_o = (idx_i & ~m) | ((idx_i + IDX_W'(1)) & m);
endmodule

// File: rtl/wb_sram_model.sv
// wb_sram_model: Wishbone B4 registered-feedback SRAM slave with byte lanes, wait states,
//   CTI/BTE bursts and out-of-range ERR
//   clk   : clock
//   rstn  : synchronous active-low reset (memory contents survive it)
//   slave : wb_if slave port (ADR, DAT_W, SEL, CYC, STB, WE, CTI, BTE in; DAT_R, ACK, ERR out)
module wb_sram_model import wb_sram_model_pkg::*; #(
  parameter int MEM_ADDR_BITS = 10,
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int WAIT_CYCLES   = 0,
  parameter int ADDR_CHECK    = 1
) (
  input logic clk,
  input logic rstn,
  wb_if.slave slave
);
  localparam int WB = $clog2(DATA_WIDTH/8);
  localparam int AW = ADDR_WIDTH - WB;
  localparam int NL = DATA_WIDTH/8;
  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [AW-1:0]         adr_q, adr_d, adr_nx;
  logic                  ack_q, err_q, go, oor, done;
  logic [DATA_WIDTH-1:0] dat_q;
  logic [DATA_WIDTH-1:0] mem [2**MEM_ADDR_BITS];
  logic                  unused_adr;
  // byte-offset bits inside a word carry no meaning here
  assign unused_adr = ^slave.ADR;
  wb_burst_addr_next #(.IDX_W(AW)) u_next (
    .idx_i  (adr_q),
    .bte_i  (bte_e'(slave.BTE)),
    .next_o (adr_nx)
  );
  assign done = slave.CYC & slave.STB & (ack_q | err_q);
  // adr_d is the address of the beat whose response is raised when go is set,
  // kept as a full word address so a burst running off the top keeps ERRing
  assign oor = ADDR_CHECK != 0 && (adr_d >> MEM_ADDR_BITS) != '0;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    adr_d = adr_q;
    go = 1'b0;
    case (state_q)
      IDLE:
        if (slave.CYC & slave.STB) begin
          adr_d = slave.ADR[ADDR_WIDTH-1:WB];
          state_d = WAIT_CYCLES > 0 ? WAIT : RESP;
          cnt_d = 4'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);
          go = WAIT_CYCLES == 0;
        end
      WAIT:
        if (!slave.CYC) state_d = IDLE;
        else if (cnt_q == 4'd0) begin
          state_d = RESP;
          go = 1'b1;
        end else cnt_d = cnt_q - 4'd1;
      RESP:
        if (!slave.CYC) state_d = IDLE;
        else if (done) begin
          // incrementing bursts respond to the next beat straight away
          if (slave.CTI == CTI_INCR) begin
            adr_d = adr_nx;
            go = 1'b1;
          end else state_d = GAP;
        end else go = slave.STB & ~(ack_q | err_q);
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q <= '0;
      adr_q <= '0;
      ack_q <= 1'b0;
      err_q <= 1'b0;
      dat_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      adr_q <= adr_d;
      ack_q <= go & ~oor;
      err_q <= go & oor;
      if (go & ~oor) dat_q <= mem[adr_d[MEM_ADDR_BITS-1:0]];
    end
  always_ff @(posedge clk)
    if (rstn & done & ack_q & slave.WE)
      for (int i = 0; i < NL; i++)
        if (slave.SEL[i]) mem[adr_q[MEM_ADDR_BITS-1:0]][i*8 +: 8] <= slave.DAT_W[i*8 +: 8];
  assign slave.DAT_R = dat_q;
  assign slave.ACK = ack_q;
  assign slave.ERR = err_q;
endmodule

// File: doc/wb_sram_model.md
# wb_sram_model

Parametrised Wishbone B4 registered-feedback SRAM slave model for block-level benches. It replaces the single-cycle, word-only SRAM BFM with the following:
- byte-lane writes
- configurable wait states
- incrementing and wrapping bursts (CTI/BTE)
- out-of-range error response
- correct word-index decoding for any power-of-two data width

It sits behind a `wb_if` slave port, wherever a bench needs backing memory.

## Interface
- `MEM_ADDR_BITS`, 10: log2 of memory depth in words.
- `ADDR_WIDTH`, 32: Wishbone byte-address width.
- `DATA_WIDTH`, 32: data width; power of two, 8..128.
- `WAIT_CYCLES`, 0: idle cycles inserted before the first ACK/ERR of each access (0..15).
- `ADDR_CHECK`, 1: when 1, byte addresses at or above `DATA_WIDTH/8 << MEM_ADDR_BITS` return ERR.
- `clk`, in, 1: clock.
- `rstn`, in, 1: reset, synchronous, active-low.
- `slave`, `wb_if` slave modport. Signals used:
  - inputs: `ADR[ADDR_WIDTH]`, `DAT_W[DATA_WIDTH]`, `SEL[DATA_WIDTH/8]`, `CYC`, `STB`, `WE`, `CTI[3]`, `BTE[2]`
  - outputs: `DAT_R[DATA_WIDTH]`, `ACK`, `ERR`

## Operation
- Word index = `ADR[MEM_ADDR_BITS+WB-1:WB]`, where `WB = $clog2(DATA_WIDTH/8)`. Upper address bits are ignored when `ADDR_CHECK=0`.
- A beat completes at the rising edge where `CYC & STB & (ACK|ERR)`.
- Writes commit at the completion edge, and only for lanes with `SEL[i]=1`. Other lanes keep their contents. ERR beats never write.
- `DAT_R` is registered and valid only while ACK is high. It holds its last value otherwise.
- State machine:
  - **IDLE**: on `CYC & STB`, latch `ADR` as the beat address. Go to WAIT if `WAIT_CYCLES>0`, else RESP.
  - **WAIT**: count down `WAIT_CYCLES`, then RESP. `CYC` low returns to IDLE.
  - **RESP**: ACK (or ERR) is high for one cycle. At completion:
    - if `CTI=3'b010`: compute the next address and stay in RESP, so back-to-back beats need no waits.
    - if `CTI` is `000` or `111`: go to GAP.
    - if `CYC` is low: go to IDLE with no commit.
  - **GAP**: one dead cycle with ACK=0, so a registered master can drop STB. Then go to IDLE.
- Burst address rules:
  - BTE `00`: linear, next = addr + 1 word.
  - BTE `01`, `10`, `11`: wrap-4, wrap-8 and wrap-16 respectively. Only the low 2, 3 or 4 word-index bits increment modulo the wrap length.
- Unsupported CTI (`001`, `011`..`110`) is treated as classic.
- ERR is decided per beat from the beat address. A burst that crosses the top of memory ERRs on the first out-of-range beat and on every beat after it.
- Memory contents are not initialised and are preserved across reset.

## Timing
- Reset values: `ACK=0`, `ERR=0`, `DAT_R=0`, state IDLE, wait counter 0.
- Classic latency: STB sampled at edge N gives ACK high in cycle N+1+`WAIT_CYCLES`. The next access is accepted no earlier than two cycles after ACK.
- Burst: after the first ACK, one beat completes per cycle for as long as `STB` is held.
- If `STB` drops mid-burst with `CYC` high, ACK drops next cycle and the state holds. Reasserted `STB` continues from the next computed address.
- `CYC` falling at any point aborts the access: no ACK/ERR next cycle, no pending write.
- Reset asserted mid-access: ACK/ERR low on the next edge and no write for that beat.
- ACK and ERR are never high in the same cycle.

## Structure
- Package `wb_sram_model_pkg` holds:
  - CTI constants: `CTI_CLASSIC`, `CTI_INCR`, `CTI_EOB`
  - BTE enum: `BTE_LINEAR`, `BTE_WRAP4`, `BTE_WRAP8`, `BTE_WRAP16`
  - state enum: `IDLE`, `WAIT`, `RESP`, `GAP`
- Sub-module `wb_burst_addr_next` is combinational: it takes the current word index and BTE and returns the next index. It is reused by future Wishbone slaves.

## Test plan
- **Classic byte-lane write/read.** Write `0xAABBCCDD` to `0x10` with `SEL=4'b1111`, then write `0x11223344` to `0x10` with `SEL=4'b0101`. Reading `0x10` returns `0xAA22CC44`. ACK arrives one cycle after STB.
- **Wait states.** With `WAIT_CYCLES=3`, a read of `0x20` raises ACK exactly 4 cycles after STB. The next ACK is never earlier than 2 cycles after the previous one.
- **Wrap-4 burst.** Burst write of data 1..4 starting at word 6, `CTI=010`, `BTE=01`, last beat `CTI=111`. Words 6,7,4,5 hold 1,2,3,4. ACK is high for 4 consecutive cycles.
- **Range check.** With `MEM_ADDR_BITS=4` and 32-bit data, a write to `0x40` returns ERR with no ACK. Memory word 0 is unchanged.
- **Aborts.** Drop `CYC` during WAIT of a write to `0x8`: no ACK is seen and the old data is retained. Assert `rstn=0` during a burst: ACK low on the next edge, and the previously written words are intact after reset.
